alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Single-command accumulator sequencer around an external ALU with
//            valid/ready command and response channels.
// Revision : 1.0  initial release
// ============================================================================

package alu_seq_pkg;
    typedef enum logic [1:0] {
        ADD = 2'b00,
        AND = 2'b01,
        OR  = 2'b10,
        XOR = 2'b11
    } ops;
endpackage

module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_load,
    input  ops           cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output ops           alu_fn,
    input  logic [W-1:0] alu_result,
    input  logic         alu_n,
    input  logic         alu_z,
    input  logic         alu_v,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_n,
    output logic         rsp_z,
    output logic         rsp_v,
    output logic [7:0]   rsp_count
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic         w_accept;
    logic [W-1:0] r_acc;
    logic [W-1:0] r_opb;
    ops           r_op;
    logic [W-1:0] r_rsp_data;
    logic         r_rsp_n;
    logic         r_rsp_z;
    logic         r_rsp_v;
    logic [7:0]   r_count;

    // Acceptance is decoded from the state directly so it never depends on
    // the registered-looking cmd_ready output path.
    assign w_accept = cmd_valid && (r_state == c_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = cmd_load ? c_RESP : c_EXEC;
                end
            end
            c_EXEC: w_state_nxt = c_RESP;
            c_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            c_IDLE:  cmd_ready = 1'b1;
            c_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Loads bypass the ALU and synthesise their own flags; operations only
    // latch their operands here and take the ALU's answer during EXEC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_opb      <= '0;
            r_op       <= ADD;
            r_rsp_data <= '0;
            r_rsp_n    <= 1'b0;
            r_rsp_z    <= 1'b0;
            r_rsp_v    <= 1'b0;
            r_count    <= 8'd0;
        end else begin
            if (w_accept) begin
                if (cmd_load) begin
                    r_acc      <= cmd_data;
                    r_rsp_data <= cmd_data;
                    r_rsp_n    <= cmd_data[W-1];
                    r_rsp_z    <= (cmd_data == '0);
                    r_rsp_v    <= 1'b0;
                end else begin
                    r_opb <= cmd_data;
                    r_op  <= cmd_op;
                end
            end
            if (r_state == c_EXEC) begin
                r_acc      <= alu_result;
                r_rsp_data <= alu_result;
                r_rsp_n    <= alu_n;
                r_rsp_z    <= alu_z;
                r_rsp_v    <= alu_v;
            end
            if ((r_state == c_RESP) && rsp_ready) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign alu_a     = r_acc;
    assign alu_b     = r_opb;
    assign alu_fn    = r_op;
    assign rsp_data  = r_rsp_data;
    assign rsp_n     = r_rsp_n;
    assign rsp_z     = r_rsp_z;
    assign rsp_v     = r_rsp_v;
    assign rsp_count = r_count;

endmodule

`default_nettype wire
